grid_argmax: RTL and testbench

GRID_ARGMAX -- requirements
Module: grid_argmax

---
 rtl/grid_argmax.sv | 145 ++++++++++++++
 tb/tb_grid_argmax.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/grid_argmax.sv
// Streaming arg-max / arg-min over a GRID_W x GRID_H raster region.
// Reports the extreme value and the coordinates where it first appeared.
module grid_argmax #(
  parameter int DATA_W = 24,
  parameter int GRID_W = 8,
  parameter int GRID_H = 8,
  localparam int XW = $clog2(GRID_W),
  localparam int YW = $clog2(GRID_H)
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_start,
  input  logic              i_mode,
  input  logic              i_clear,
  input  logic              i_valid,
  output logic              o_ready,
  input  logic [DATA_W-1:0] i_data,
  output logic              o_valid,
  input  logic              i_ready,
  output logic [DATA_W-1:0] o_ext,
  output logic [XW-1:0]     o_x,
  output logic [YW-1:0]     o_y,
  output logic              o_busy
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ACC  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam logic [XW-1:0] X_LAST = XW'(GRID_W - 1);
  localparam logic [YW-1:0] Y_LAST = YW'(GRID_H - 1);

  state_t            state_r;
  state_t            state_s;
  logic [XW-1:0]     x_r;
  logic [YW-1:0]     y_r;
  logic              mode_r;
  logic              seen_r;
  logic              valid_r;
  logic              ready_r;
  logic              busy_r;
  logic [DATA_W-1:0] ext_r;
  logic [XW-1:0]     ox_r;
  logic [YW-1:0]     oy_r;

  logic accept_s;
  logic last_s;
  logic xfer_s;
  logic better_s;
  logic update_s;

  // Next-state decode, pixel acceptance and strict compare against the running extreme
  always_comb begin
    accept_s = i_valid && ready_r;
    last_s   = accept_s && (x_r == X_LAST) && (y_r == Y_LAST);
    xfer_s   = valid_r && i_ready;
    if (mode_r) begin
      better_s = (i_data < ext_r);
    end else begin
      better_s = (i_data > ext_r);
    end
    // Strict compare keeps the earliest pixel on ties; clear suppresses the update
    update_s = accept_s && !i_clear && (!seen_r || better_s);
    state_s  = state_r;
    if (i_clear) begin
      state_s = ST_IDLE;
    end else begin
      case (state_r)
        ST_IDLE: if (i_start) state_s = ST_ACC;  else state_s = ST_IDLE;
        ST_ACC:  if (last_s)  state_s = ST_DONE; else state_s = ST_ACC;
        ST_DONE: if (xfer_s)  state_s = ST_IDLE; else state_s = ST_DONE;
        default: state_s = ST_IDLE;
      endcase
    end
  end

  // State register with handshake/status flags registered from the next state
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_r <= ST_IDLE;
      valid_r <= 1'b0;
      ready_r <= 1'b0;
      busy_r  <= 1'b0;
    end else begin
      state_r <= state_s;
      valid_r <= (state_s == ST_DONE);
      ready_r <= (state_s == ST_ACC);
      busy_r  <= (state_s != ST_IDLE);
    end
  end

  // Raster coordinate counters, search mode and first-pixel flag
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      x_r    <= '0;
      y_r    <= '0;
      mode_r <= 1'b0;
      seen_r <= 1'b0;
    end else if (i_clear) begin
      x_r    <= '0;
      y_r    <= '0;
      seen_r <= 1'b0;
    end else if ((state_r == ST_IDLE) && i_start) begin
      x_r    <= '0;
      y_r    <= '0;
      mode_r <= i_mode;
      seen_r <= 1'b0;
    end else if (accept_s) begin
      seen_r <= 1'b1;
      if (x_r == X_LAST) begin
        x_r <= '0;
        if (y_r == Y_LAST) begin
          y_r <= '0;
        end else begin
          y_r <= y_r + YW'(1);
        end
      end else begin
        x_r <= x_r + XW'(1);
      end
    end
  end

  // Running extreme doubles as the result register; only updates or reset touch it
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      ext_r <= '0;
      ox_r  <= '0;
      oy_r  <= '0;
    end else if (update_s) begin
      ext_r <= i_data;
      ox_r  <= x_r;
      oy_r  <= y_r;
    end
  end

  assign o_ready = ready_r;
  assign o_valid = valid_r;
  assign o_busy  = busy_r;
  assign o_ext   = ext_r;
  assign o_x     = ox_r;
  assign o_y     = oy_r;

endmodule

// File: tb/tb_grid_argmax.sv
// Bench for grid_argmax: vector table with scoreboard, plus clear, reset and
// small-grid sequences.
module tb_grid_argmax;

  logic        clk;
  logic        rst_n;
  logic        i_start, i_mode, i_clear, i_valid, i_ready;
  logic [23:0] i_data;
  logic        o_ready, o_valid, o_busy;
  logic [23:0] o_ext;
  logic [2:0]  o_x, o_y;

  logic       s_start, s_mode, s_clear, s_valid, s_rdy;
  logic [7:0] s_data;
  logic       s_ready_o, s_valid_o, s_busy;
  logic [7:0] s_ext;
  logic [1:0] s_x;
  logic [0:0] s_y;

  int total = 0;
  int bad   = 0;

  typedef struct packed {
    logic [23:0] ext;
    logic [2:0]  x;
    logic [2:0]  y;
  } res_t;
  res_t sb[$];

  typedef struct {
    logic        mode;
    int          kind;
    bit          gaps;
    int          hold;
    logic [23:0] ext;
    logic [2:0]  x;
    logic [2:0]  y;
  } vec_t;
  vec_t vecs[7];

  grid_argmax dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(i_start), .i_mode(i_mode),
    .i_clear(i_clear), .i_valid(i_valid), .o_ready(o_ready), .i_data(i_data),
    .o_valid(o_valid), .i_ready(i_ready), .o_ext(o_ext), .o_x(o_x), .o_y(o_y),
    .o_busy(o_busy)
  );

  grid_argmax #(.DATA_W(8), .GRID_W(4), .GRID_H(2)) dut_s (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(s_start), .i_mode(s_mode),
    .i_clear(s_clear), .i_valid(s_valid), .o_ready(s_ready_o), .i_data(s_data),
    .o_valid(s_valid_o), .i_ready(s_rdy), .o_ext(s_ext), .o_x(s_x), .o_y(s_y),
    .o_busy(s_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [23:0] pix(input int kind, input int x, input int y);
    case (kind)
      0: pix = 24'(y * 8 + x);
      1: pix = (y == 5 && (x == 3 || x == 6)) ? 24'h000010 : 24'hFFFFFF;
      2: pix = 24'h123456;
      3: pix = 24'(63 - (y * 8 + x));
      4: pix = (x == 5 && y == 2) ? 24'h800000 : 24'h7FFFFF;
      default: pix = 24'h0;
    endcase
  endfunction

  // Scoreboard: pop and compare on every result transfer
  always @(negedge clk) begin
    if (rst_n && o_valid && i_ready) begin
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_result: got ext=0x%0h with no expected entry", o_ext);
      end else begin
        res_t e;
        e = sb.pop_front();
        check("sb_ext", 32'(o_ext), 32'(e.ext));
        check("sb_x", 32'(o_x), 32'(e.x));
        check("sb_y", 32'(o_y), 32'(e.y));
      end
    end
  end

  // Start a region and feed all 64 pixels; returns #1 after the last acceptance edge
  task automatic feed(input logic mode, input int kind, input bit gaps, output int lat);
    int n, cyc, first, guard;
    i_mode  = mode;
    i_start = 1'b1;
    @(negedge clk);
    @(posedge clk); #1;
    i_start = 1'b0;
    n = 0; cyc = 0; first = -1; guard = 0;
    while (n < 64 && guard < 2000) begin
      i_valid = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
      i_data  = pix(kind, n % 8, n / 8);
      @(negedge clk);
      if (i_valid && o_ready) begin
        if (first < 0) first = cyc;
        n++;
      end
      @(posedge clk); #1;
      cyc++;
      guard++;
    end
    i_valid = 1'b0;
    check("pixels_accepted", 32'(n), 32'd64);
    if (!gaps) check("first_accept_cycle", 32'(first), 32'd0);
    lat = cyc - first + 1;
  endtask

  // DONE phase: latency, hold stability, transfer with an ignored coincident start
  task automatic done_phase(input bit gaps, input int hold, input int lat);
    logic [23:0] c_ext;
    logic [2:0]  c_x, c_y;
    @(negedge clk);
    check("done_valid", 32'(o_valid), 32'd1);
    check("done_ready", 32'(o_ready), 32'd0);
    check("done_busy", 32'(o_busy), 32'd1);
    if (!gaps) check("latency", 32'(lat), 32'd65);
    c_ext = o_ext; c_x = o_x; c_y = o_y;
    for (int i = 0; i < hold; i++) begin
      check("hold_valid", 32'(o_valid), 32'd1);
      check("hold_ready", 32'(o_ready), 32'd0);
      check("hold_ext", 32'(o_ext), 32'(c_ext));
      check("hold_xy", 32'({o_x, o_y}), 32'({c_x, c_y}));
      @(posedge clk); #1;
      if (i == hold - 1) i_ready = 1'b1;
      @(negedge clk);
    end
    i_start = 1'b1;
    @(posedge clk); #1;
    i_start = 1'b0;
    @(negedge clk);
    check("post_xfer_valid", 32'(o_valid), 32'd0);
    check("post_xfer_busy", 32'(o_busy), 32'd0);
    @(posedge clk); #1;
  endtask

  initial begin
    int lat;
    int cyc;
    vecs[0] = '{1'b0, 0, 1'b0, 0,  24'd63,      3'd7, 3'd7};
    vecs[1] = '{1'b1, 1, 1'b0, 0,  24'h000010,  3'd3, 3'd5};
    vecs[2] = '{1'b0, 2, 1'b0, 0,  24'h123456,  3'd0, 3'd0};
    vecs[3] = '{1'b1, 0, 1'b0, 0,  24'd0,       3'd0, 3'd0};
    vecs[4] = '{1'b0, 4, 1'b0, 3,  24'h800000,  3'd5, 3'd2};
    vecs[5] = '{1'b1, 3, 1'b0, 0,  24'd0,       3'd7, 3'd7};
    vecs[6] = '{1'b0, 0, 1'b1, 10, 24'd63,      3'd7, 3'd7};

    rst_n = 1'b1;
    i_start = 1'b0; i_mode = 1'b0; i_clear = 1'b0; i_valid = 1'b0;
    i_ready = 1'b0; i_data = 24'h0;
    s_start = 1'b0; s_mode = 1'b0; s_clear = 1'b0; s_valid = 1'b0;
    s_rdy = 1'b1; s_data = 8'h0;
    #3 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_valid", 32'(o_valid), 32'd0);
    check("rst_ready", 32'(o_ready), 32'd0);
    check("rst_busy", 32'(o_busy), 32'd0);
    check("rst_ext", 32'(o_ext), 32'd0);
    check("rst_xy", 32'({o_x, o_y}), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    for (int v = 0; v < 7; v++) begin
      sb.push_back('{vecs[v].ext, vecs[v].x, vecs[v].y});
      i_ready = (vecs[v].hold == 0);
      feed(vecs[v].mode, vecs[v].kind, vecs[v].gaps, lat);
      done_phase(vecs[v].gaps, vecs[v].hold, lat);
    end

    // Abort after 20 pixels; the 21st pixel and a start coincide with clear
    i_ready = 1'b1;
    i_mode = 1'b0;
    i_start = 1'b1;
    @(posedge clk); #1;
    i_start = 1'b0;
    for (int n = 0; n < 20; n++) begin
      i_valid = 1'b1;
      i_data = 24'(n);
      @(posedge clk); #1;
    end
    i_valid = 1'b1; i_data = 24'd20; i_clear = 1'b1; i_start = 1'b1;
    @(posedge clk); #1;
    i_valid = 1'b0; i_clear = 1'b0; i_start = 1'b0;
    @(negedge clk);
    check("clr_busy", 32'(o_busy), 32'd0);
    check("clr_ready", 32'(o_ready), 32'd0);
    check("clr_ext_kept", 32'(o_ext), 32'd19);
    check("clr_xy_kept", 32'({o_x, o_y}), 32'({3'd3, 3'd2}));
    for (int i = 0; i < 4; i++) begin
      check("clr_no_valid", 32'(o_valid), 32'd0);
      @(negedge clk);
    end
    @(posedge clk); #1;
    sb.push_back('{24'h000010, 3'd3, 3'd5});
    feed(1'b1, 1, 1'b0, lat);
    done_phase(1'b0, 0, lat);

    // Reset while a result waits in DONE
    i_ready = 1'b0;
    feed(1'b0, 2, 1'b0, lat);
    @(negedge clk);
    check("pre_rst_valid", 32'(o_valid), 32'd1);
    rst_n = 1'b0;
    #1;
    check("async_rst_valid", 32'(o_valid), 32'd0);
    check("async_rst_busy", 32'(o_busy), 32'd0);
    check("async_rst_ready", 32'(o_ready), 32'd0);
    check("async_rst_ext", 32'(o_ext), 32'd0);
    check("async_rst_xy", 32'({o_x, o_y}), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    sb.push_back('{24'd63, 3'd7, 3'd7});
    i_ready = 1'b1;
    feed(1'b0, 0, 1'b0, lat);
    done_phase(1'b0, 0, lat);

    // Small 4x2 grid, 8-bit data, peak at (2,1)
    s_start = 1'b1;
    @(posedge clk); #1;
    s_start = 1'b0;
    cyc = 0;
    for (int n = 0; n < 8; n++) begin
      s_valid = 1'b1;
      s_data = (n == 6) ? 8'hFF : 8'(n * 3);
      @(negedge clk);
      check("small_ready", 32'(s_ready_o), 32'd1);
      @(posedge clk); #1;
      cyc++;
    end
    s_valid = 1'b0;
    @(negedge clk);
    check("small_valid", 32'(s_valid_o), 32'd1);
    check("small_latency", 32'(cyc + 1), 32'd9);
    check("small_ext", 32'(s_ext), 32'hFF);
    check("small_x", 32'(s_x), 32'd2);
    check("small_y", 32'(s_y), 32'd1);
    @(posedge clk); #1;
    @(negedge clk);
    check("small_post_valid", 32'(s_valid_o), 32'd0);

    check("sb_drained", 32'(sb.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
